stepper_sys_info: RTL and testbench

Parametrised system-information slave for the StepperMotorControl Qsys system. It provides an Avalon-MM read/write register window that holds the constant system ID and build timestamp, plus a version word, channel count, a scratch register, a free-running uptime counter with coherent 64-bit reads, and a sticky status word. Nios II software uses it to identify the hardware build and measure elapsed time. It sits on the same control bus as the other peripheral slaves.

---
 rtl/stepper_sys_info_pkg.sv | 25 ++
 rtl/stepper_uptime_counter.sv | 31 +++
 rtl/stepper_sys_info.sv | 124 ++++++++++++
 tb/tb_stepper_sys_info.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_sys_info_pkg.sv
// Shared constants for the system-information slave: register offsets and STATUS bits.
// Latency: n/a (package).
// Backpressure: n/a (package).
package stepper_sys_info_pkg;

    localparam int DATA_W = 32;

    localparam int OFS_SYSTEM_ID = 0;
    localparam int OFS_TIMESTAMP = 1;
    localparam int OFS_VERSION   = 2;
    localparam int OFS_SCRATCH   = 3;
    localparam int OFS_UPTIME_LO = 4;
    localparam int OFS_UPTIME_HI = 5;
    localparam int OFS_CHANNELS  = 6;
    localparam int OFS_STATUS    = 7;

    localparam int STAT_WRAP = 0;

    // One stage of the read-return pipeline.
    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] dat;
    } rd_beat_t;

endpackage

// File: rtl/stepper_uptime_counter.sv
// Free-running uptime counter with synchronous clear and a wrap indication.
// Latency: count updates at every edge; wrap is high in the cycle before the roll-over edge.
// Backpressure: none, counts unconditionally.
module stepper_uptime_counter #(
    parameter int UPTIME_W = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    output logic [UPTIME_W-1:0] count,
    output logic                wrap
);

    logic [UPTIME_W-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + UPTIME_W'(1);
        end
    end

    // The increment at the next edge rolls over; reported even when a clear
    // overrides it so the sticky flag still records the wrap.
    assign wrap  = &count_q;
    assign count = count_q;

endmodule

// File: rtl/stepper_sys_info.sv
// Avalon-MM system-information slave: IDs, scratch, uptime with coherent 64-bit reads, sticky status.
// Latency: LATENCY cycles from read strobe to readdatavalid, fully pipelined.
// Backpressure: none (no waitrequest); read+write together performs the write and drops the read.
module stepper_sys_info
    import stepper_sys_info_pkg::*;
#(
    parameter int          ADDR_W       = 3,
    parameter logic [31:0] SYSTEM_ID    = 32'h0400_0000,
    parameter logic [31:0] TIMESTAMP    = 32'h545A_70F2,
    parameter logic [31:0] VERSION      = 32'h0001_0000,
    parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000,
    parameter int          CHANNELS     = 1,
    parameter int          UPTIME_W     = 64,
    parameter int          LATENCY      = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam int HI_W = UPTIME_W - 32;

    if (ADDR_W < 3) begin : g_bad_addr_w
        $error("stepper_sys_info: ADDR_W must be at least 3");
    end
    if (UPTIME_W < 33 || UPTIME_W > 64) begin : g_bad_uptime_w
        $error("stepper_sys_info: UPTIME_W must be within 33..64");
    end
    if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
        $error("stepper_sys_info: LATENCY must be within 1..3");
    end

    logic [UPTIME_W-1:0] count;
    logic                wrap;
    logic                rd_en;
    logic                hit_scratch_wr;
    logic                hit_clear;
    logic                hit_w1c;
    logic                hit_latch;
    logic [31:0]         scratch_q;
    logic [HI_W-1:0]     hi_shadow_q;
    logic                sticky_q;
    logic [DATA_W-1:0]   rd_mux;
    rd_beat_t            pipe_q [LATENCY];

    // A colliding write always wins; the read is simply never issued.
    assign rd_en          = read & ~write;
    assign hit_scratch_wr = write && (address == ADDR_W'(OFS_SCRATCH));
    assign hit_clear      = write && (address == ADDR_W'(OFS_UPTIME_LO));
    assign hit_w1c        = write && (address == ADDR_W'(OFS_STATUS)) && writedata[STAT_WRAP];
    assign hit_latch      = rd_en && (address == ADDR_W'(OFS_UPTIME_LO));

    stepper_uptime_counter #(
        .UPTIME_W (UPTIME_W)
    ) u_cnt (
        .clock (clock),
        .reset (reset),
        .clear (hit_clear),
        .count (count),
        .wrap  (wrap)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scratch_q   <= SCRATCH_INIT;
            hi_shadow_q <= '0;
            sticky_q    <= 1'b0;
        end else begin
            if (hit_scratch_wr) begin
                scratch_q <= writedata;
            end
            if (hit_latch) begin
                hi_shadow_q <= count[UPTIME_W-1:32];
            end
            // A wrap in the same cycle as a W1C leaves the flag set.
            sticky_q <= wrap | (sticky_q & ~hit_w1c);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_W'(OFS_SYSTEM_ID): rd_mux = SYSTEM_ID;
            ADDR_W'(OFS_TIMESTAMP): rd_mux = TIMESTAMP;
            ADDR_W'(OFS_VERSION):   rd_mux = VERSION;
            ADDR_W'(OFS_SCRATCH):   rd_mux = scratch_q;
            ADDR_W'(OFS_UPTIME_LO): rd_mux = count[31:0];
            ADDR_W'(OFS_UPTIME_HI): rd_mux = DATA_W'(hi_shadow_q);
            ADDR_W'(OFS_CHANNELS):  rd_mux = DATA_W'(CHANNELS);
            ADDR_W'(OFS_STATUS):    rd_mux[STAT_WRAP] = sticky_q;
            default:                rd_mux = '0;
        endcase
    end

    // Data moves only with a valid beat, so the last stage holds the most
    // recent return between pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0].vld <= rd_en;
            if (rd_en) begin
                pipe_q[0].dat <= rd_mux;
            end
            for (int i = 1; i < LATENCY; i++) begin
                pipe_q[i].vld <= pipe_q[i-1].vld;
                if (pipe_q[i-1].vld) begin
                    pipe_q[i].dat <= pipe_q[i-1].dat;
                end
            end
        end
    end

    assign readdata      = pipe_q[LATENCY-1].dat;
    assign readdatavalid = pipe_q[LATENCY-1].vld;

endmodule

// File: tb/tb_stepper_sys_info.sv
// Directed bench for stepper_sys_info: one LATENCY=1 instance (34-bit uptime, 16-word window)
// and one LATENCY=3 instance with default parameters.
module tb_stepper_sys_info;

    localparam logic [1:0] OP_RD = 2'd1;
    localparam logic [1:0] OP_WR = 2'd2;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [31:0] wdat;
        logic        exp_vld;
        logic [31:0] exp_dat;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_rd, a_wr, a_rvld;
    logic [3:0]  a_addr;
    logic [31:0] a_wdat, a_rdat;
    logic        b_rst, b_rd, b_wr, b_rvld;
    logic [2:0]  b_addr;
    logic [31:0] b_wdat, b_rdat;

    int n_cmp = 0;
    int n_err = 0;

    stepper_sys_info #(
        .ADDR_W       (4),
        .SCRATCH_INIT (32'h0BAD_F00D),
        .UPTIME_W     (34),
        .LATENCY      (1)
    ) u_a (
        .clock         (clk),
        .reset         (a_rst),
        .address       (a_addr),
        .read          (a_rd),
        .write         (a_wr),
        .writedata     (a_wdat),
        .readdata      (a_rdat),
        .readdatavalid (a_rvld)
    );

    stepper_sys_info #(
        .LATENCY (3)
    ) u_b (
        .clock         (clk),
        .reset         (b_rst),
        .address       (b_addr),
        .read          (b_rd),
        .write         (b_wr),
        .writedata     (b_wdat),
        .readdata      (b_rdat),
        .readdatavalid (b_rvld)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic a_op(input logic rd, input logic wr, input logic [3:0] addr, input logic [31:0] dat);
        a_rd   = rd;
        a_wr   = wr;
        a_addr = addr;
        a_wdat = dat;
    endtask

    vec_t        tbl [16];
    logic [31:0] b_exp1 [5];
    logic [31:0] b_exp2 [4];
    logic [2:0]  b_adr1 [5];
    logic [2:0]  b_adr2 [4];

    initial begin
        tbl[0]  = '{OP_RD, 4'd0,  32'h0,         1'b1, 32'h0400_0000};
        tbl[1]  = '{OP_RD, 4'd1,  32'h0,         1'b1, 32'h545A_70F2};
        tbl[2]  = '{OP_RD, 4'd2,  32'h0,         1'b1, 32'h0001_0000};
        tbl[3]  = '{OP_RD, 4'd6,  32'h0,         1'b1, 32'h0000_0001};
        tbl[4]  = '{OP_RD, 4'd9,  32'h0,         1'b1, 32'h0000_0000};
        tbl[5]  = '{OP_RD, 4'd3,  32'h0,         1'b1, 32'h0BAD_F00D};
        tbl[6]  = '{OP_WR, 4'd3,  32'hDEAD_BEEF, 1'b0, 32'h0BAD_F00D};
        tbl[7]  = '{OP_RD, 4'd3,  32'h0,         1'b1, 32'hDEAD_BEEF};
        tbl[8]  = '{OP_WR, 4'd0,  32'h1234_5678, 1'b0, 32'hDEAD_BEEF};
        tbl[9]  = '{OP_RD, 4'd0,  32'h0,         1'b1, 32'h0400_0000};
        tbl[10] = '{OP_WR, 4'd9,  32'hFFFF_FFFF, 1'b0, 32'h0400_0000};
        tbl[11] = '{OP_RD, 4'd9,  32'h0,         1'b1, 32'h0000_0000};
        tbl[12] = '{OP_RD, 4'd7,  32'h0,         1'b1, 32'h0000_0000};
        tbl[13] = '{OP_WR, 4'd7,  32'h0000_0001, 1'b0, 32'h0000_0000};
        tbl[14] = '{OP_RD, 4'd15, 32'h0,         1'b1, 32'h0000_0000};
        tbl[15] = '{OP_RD, 4'd5,  32'h0,         1'b1, 32'h0000_0000};

        b_adr1 = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd3};
        b_exp1 = '{32'h0400_0000, 32'h545A_70F2, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        b_adr2 = '{3'd1, 3'd2, 3'd0, 3'd6};
        b_exp2 = '{32'h545A_70F2, 32'h0001_0000, 32'h0400_0000, 32'h0000_0001};

        a_rst = 1'b1;
        b_rst = 1'b1;
        a_op(1'b1, 1'b0, 4'd0, 32'h0);
        b_rd = 1'b1; b_wr = 1'b0; b_addr = 3'd0; b_wdat = 32'h0;

        // Outputs stay zero while reset is held, even with a read strobe pending.
        repeat (3) @(negedge clk);
        chk("rst_a_dat", a_rdat, 32'h0);
        chk("rst_a_vld", 32'(a_rvld), 32'h0);
        chk("rst_b_dat", b_rdat, 32'h0);
        chk("rst_b_vld", 32'(b_rvld), 32'h0);
        a_op(1'b0, 1'b0, 4'd0, 32'h0);
        b_rd = 1'b0;
        a_rst = 1'b0;
        b_rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a_op(tbl[i].op == OP_RD, tbl[i].op == OP_WR, tbl[i].addr, tbl[i].wdat);
            @(negedge clk);
            a_op(1'b0, 1'b0, 4'd0, 32'h0);
            chk($sformatf("tbl%0d_vld", i), 32'(a_rvld), 32'(tbl[i].exp_vld));
            chk($sformatf("tbl%0d_dat", i), a_rdat, tbl[i].exp_dat);
        end

        // Write then read SCRATCH on the very next cycle.
        @(negedge clk); a_op(1'b0, 1'b1, 4'd3, 32'hCAFE_F00D);
        @(negedge clk); a_op(1'b1, 1'b0, 4'd3, 32'h0);
        @(negedge clk); a_op(1'b0, 1'b0, 4'd0, 32'h0);
        chk("wr_rd_scratch", a_rdat, 32'hCAFE_F00D);
        chk("wr_rd_vld", 32'(a_rvld), 32'h1);

        // Clearing the counter: reads on the two following edges see 0 then 1.
        @(negedge clk); a_op(1'b0, 1'b1, 4'd4, 32'h0000_0005);
        @(negedge clk); a_op(1'b1, 1'b0, 4'd4, 32'h0);
        @(negedge clk);
        chk("clr_lo0", a_rdat, 32'h0);
        @(negedge clk); a_op(1'b1, 1'b0, 4'd5, 32'h0);
        chk("clr_lo1", a_rdat, 32'h1);
        @(negedge clk); a_op(1'b0, 1'b0, 4'd0, 32'h0);
        chk("clr_hi", a_rdat, 32'h0);

        // LO/HI pair across a carry into bit 32 must not tear.
        @(negedge clk);
        force u_a.u_cnt.count_q = 34'h2_FFFF_FFFF;
        a_op(1'b1, 1'b0, 4'd4, 32'h0);
        #1 release u_a.u_cnt.count_q;
        @(negedge clk); a_op(1'b1, 1'b0, 4'd5, 32'h0);
        chk("tear_lo", a_rdat, 32'hFFFF_FFFF);
        @(negedge clk); a_op(1'b0, 1'b0, 4'd0, 32'h0);
        chk("tear_hi", a_rdat, 32'h0000_0002);
        chk("tear_hi_vld", 32'(a_rvld), 32'h1);

        // Wrap: the flag becomes visible to a read sampled after the roll-over edge.
        @(negedge clk);
        force u_a.u_cnt.count_q = 34'h3_FFFF_FFFE;
        a_op(1'b1, 1'b0, 4'd7, 32'h0);
        #1 release u_a.u_cnt.count_q;
        @(negedge clk);
        chk("wrap_pre0", a_rdat, 32'h0);
        @(negedge clk);
        chk("wrap_pre1", a_rdat, 32'h0);
        @(negedge clk); a_op(1'b0, 1'b1, 4'd7, 32'h0);
        chk("wrap_set", a_rdat, 32'h1);
        @(negedge clk); a_op(1'b1, 1'b0, 4'd7, 32'h0);
        @(negedge clk); a_op(1'b0, 1'b1, 4'd7, 32'h1);
        chk("w0_keeps", a_rdat, 32'h1);
        @(negedge clk); a_op(1'b1, 1'b0, 4'd7, 32'h0);
        @(negedge clk); a_op(1'b0, 1'b0, 4'd0, 32'h0);
        chk("w1_clears", a_rdat, 32'h0);

        // Wrap and W1C on the same edge: the flag stays set.
        @(negedge clk);
        force u_a.u_cnt.count_q = 34'h3_FFFF_FFFF;
        a_op(1'b0, 1'b1, 4'd7, 32'h1);
        #1 release u_a.u_cnt.count_q;
        @(negedge clk); a_op(1'b1, 1'b0, 4'd7, 32'h0);
        @(negedge clk); a_op(1'b0, 1'b1, 4'd7, 32'h1);
        chk("set_beats_w1c", a_rdat, 32'h1);

        // Clear and wrap on the same edge: counter is 0 and the flag is set.
        @(negedge clk);
        force u_a.u_cnt.count_q = 34'h3_FFFF_FFFF;
        a_op(1'b0, 1'b1, 4'd4, 32'h0);
        #1 release u_a.u_cnt.count_q;
        @(negedge clk); a_op(1'b1, 1'b0, 4'd4, 32'h0);
        @(negedge clk); a_op(1'b1, 1'b0, 4'd7, 32'h0);
        chk("clr_wrap_cnt", a_rdat, 32'h0);
        @(negedge clk); a_op(1'b0, 1'b0, 4'd0, 32'h0);
        chk("clr_wrap_flag", a_rdat, 32'h1);

        // Read and write together: write lands, no return.
        @(negedge clk); a_op(1'b1, 1'b1, 4'd3, 32'h1234_5678);
        @(negedge clk); a_op(1'b1, 1'b0, 4'd3, 32'h0);
        chk("rw_no_vld", 32'(a_rvld), 32'h0);
        @(negedge clk); a_op(1'b0, 1'b0, 4'd0, 32'h0);
        chk("rw_scratch", a_rdat, 32'h1234_5678);

        // Reset restores SCRATCH_INIT and clears the sticky flag.
        @(negedge clk); a_rst = 1'b1;
        #1;
        chk("mid_rst_dat", a_rdat, 32'h0);
        @(negedge clk); a_rst = 1'b0;
        @(negedge clk); a_op(1'b1, 1'b0, 4'd3, 32'h0);
        @(negedge clk); a_op(1'b1, 1'b0, 4'd7, 32'h0);
        chk("rst_scratch", a_rdat, 32'h0BAD_F00D);
        @(negedge clk); a_op(1'b0, 1'b0, 4'd0, 32'h0);
        chk("rst_sticky", a_rdat, 32'h0);

        // LATENCY=3: five back-to-back reads, returns observed three cycles on.
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk($sformatf("b1_vld%0d", j), 32'(b_rvld), 32'(j >= 3 && j <= 7));
            if (j >= 3 && j <= 7) begin
                chk($sformatf("b1_dat%0d", j), b_rdat, b_exp1[j-3]);
            end
            b_rd   = (j < 5);
            b_addr = (j < 5) ? b_adr1[j] : 3'd0;
        end
        chk("b1_hold", b_rdat, 32'h0);

        // Reset during the second return aborts everything still in flight.
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j == 4) begin
                b_rst = 1'b1;
                #1;
                chk("b2_rst_vld", 32'(b_rvld), 32'h0);
                chk("b2_rst_dat", b_rdat, 32'h0);
            end else begin
                if (j == 5) b_rst = 1'b0;
                chk($sformatf("b2_vld%0d", j), 32'(b_rvld), 32'(j == 3));
                if (j == 3) chk("b2_dat3", b_rdat, b_exp2[0]);
            end
            b_rd   = (j < 4);
            b_addr = (j < 4) ? b_adr2[j] : 3'd0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
